// File: rtl/mem_bus_pkg.sv
// Shared types and helpers for the stalled-RAM bus slave.
// Holds the reset-vector constant, byte-enable type, bus state encoding and the LFSR step.
package mem_bus_pkg;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

    typedef logic [3:0] byteen_t;

    typedef enum logic [0:0] {
        BUS_IDLE  = 1'b0,
        BUS_STALL = 1'b1
    } bus_state_t;

    // Fibonacci LFSR for x^8+x^6+x^5+x^4+1, shifting towards the MSB.
    function automatic logic [7:0] lfsr8_next(input logic [7:0] state);
        return {state[6:0], state[7] ^ state[5] ^ state[4] ^ state[3]};
    endfunction

endpackage

// File: rtl/bus_wait_ram_if.sv
// Avalon-style memory bus between the CPU master and the wait-state RAM slave.
interface bus_wait_ram_if;
    import mem_bus_pkg::*;

    logic [31:0] address;
    logic        write;
    logic        read;
    logic        waitrequest;
    logic [31:0] writedata;
    byteen_t     byteenable;
    logic [31:0] readdata;
    logic        protocol_error;

    modport master (
        output address, write, read, writedata, byteenable,
        input  waitrequest, readdata, protocol_error
    );

    modport slave (
        input  address, write, read, writedata, byteenable,
        output waitrequest, readdata, protocol_error
    );

endinterface

// File: rtl/bus_wait_gen.sv
// Stall generator: picks a per-transfer stall target, counts stall cycles,
// drives waitrequest and flags the accept edge and the first cycle of a request.
module bus_wait_gen
    import mem_bus_pkg::*;
#(
    parameter int         WAIT_CYCLES = 0,
    parameter bit         RANDOM_WAIT = 1'b0,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    output logic waitrequest,
    output logic accept,
    output logic start
);

    localparam logic [7:0] FIXED_T = 8'(WAIT_CYCLES);

    bus_state_t state_r;
    bus_state_t state_nxt_s;
    logic [7:0] cnt_r;
    logic [7:0] cnt_nxt_s;
    logic [7:0] target_r;
    logic [7:0] target_s;
    logic [7:0] fresh_s;
    logic [7:0] lfsr_r;

    assign fresh_s = RANDOM_WAIT ? {6'b000000, lfsr_r[1:0]} : FIXED_T;

    // Stall decision: a new request uses the live target, a stalled one the captured target.
    always_comb begin
        target_s    = target_r;
        waitrequest = 1'b0;
        accept      = 1'b0;
        start       = 1'b0;
        cnt_nxt_s   = 8'd0;
        state_nxt_s = state_r;
        if (state_r == BUS_IDLE) begin
            target_s = fresh_s;
        end else begin
            target_s = target_r;
        end
        waitrequest = req && (cnt_r != target_s);
        accept      = req && !waitrequest;
        start       = req && (state_r == BUS_IDLE);
        if (req && !accept) begin
            cnt_nxt_s = cnt_r + 8'd1;
        end else begin
            cnt_nxt_s = 8'd0;
        end
        case (state_r)
            BUS_IDLE: begin
                if (req && !accept) begin
                    state_nxt_s = BUS_STALL;
                end else begin
                    state_nxt_s = BUS_IDLE;
                end
            end
            BUS_STALL: begin
                if (req && !accept) begin
                    state_nxt_s = BUS_STALL;
                end else begin
                    state_nxt_s = BUS_IDLE;
                end
            end
            default: state_nxt_s = BUS_IDLE;
        endcase
    end

    // State, counter, captured target and LFSR registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= BUS_IDLE;
            cnt_r    <= 8'd0;
            target_r <= 8'd0;
            lfsr_r   <= LFSR_SEED;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (start) begin
                target_r <= fresh_s;
            end
            // The LFSR only moves on accepted transfers so a stall target stays put while held.
            if (RANDOM_WAIT && accept) begin
                lfsr_r <= lfsr8_next(lfsr_r);
            end
        end
    end

endmodule

// File: rtl/bus_wait_ram.sv
// Word-addressed RAM slave with programmable or pseudo-random wait states,
// byte-lane writes, a registered read port and a sticky bus protocol checker.
module bus_wait_ram
    import mem_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = RESET_VECTOR,
    parameter int          DEPTH_WORDS = 64,
    parameter int          WAIT_CYCLES = 0,
    parameter bit          RANDOM_WAIT = 1'b0,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic           clk,
    input  logic           reset,
    bus_wait_ram_if.slave  bus
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [31:0]      mem_r [DEPTH_WORDS];
    logic [31:0]      readdata_r;
    logic             perr_r;
    logic [31:0]      addr_cap_r;
    logic [31:0]      wdata_cap_r;
    byteen_t          be_cap_r;
    logic [1:0]       kind_cap_r;

    logic [31:0]      offset_s;
    logic [IDX_W-1:0] idx_s;
    logic             in_range_s;
    logic             req_s;
    logic             both_s;
    logic             wait_s;
    logic             accept_s;
    logic             start_s;
    logic             stalled_s;
    logic             changed_s;
    logic             rd_en_s;
    logic             wr_en_s;

    assign req_s  = bus.read | bus.write;
    assign both_s = bus.read & bus.write;

    bus_wait_gen #(
        .WAIT_CYCLES (WAIT_CYCLES),
        .RANDOM_WAIT (RANDOM_WAIT),
        .LFSR_SEED   (LFSR_SEED)
    ) u_wait_gen (
        .clk         (clk),
        .reset       (reset),
        .req         (req_s),
        .waitrequest (wait_s),
        .accept      (accept_s),
        .start       (start_s)
    );

    // Address decode; the subtraction wraps so addresses below the base fail the range test.
    always_comb begin
        offset_s   = bus.address - BASE_ADDR;
        idx_s      = offset_s[IDX_W+1:2];
        in_range_s = (bus.address >= BASE_ADDR) && ((offset_s >> 2'd2) < 32'(DEPTH_WORDS));
    end

    // Transfer qualification and mid-stall change detection against the first-seen request.
    always_comb begin
        stalled_s = req_s & ~start_s;
        changed_s = ({bus.read, bus.write} != kind_cap_r) ||
                    (bus.address != addr_cap_r)          ||
                    (bus.writedata != wdata_cap_r)       ||
                    (bus.byteenable != be_cap_r);
        rd_en_s   = accept_s & bus.read & ~bus.write & ~reset;
        wr_en_s   = accept_s & bus.write & ~bus.read & in_range_s & ~reset;
    end

    // Byte-lane RAM write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en_s && bus.byteenable[i]) begin
                mem_r[idx_s][8*i +: 8] <= bus.writedata[8*i +: 8];
            end
        end
    end

    // Read data register, request capture and sticky protocol error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata_r  <= 32'h0000_0000;
            perr_r      <= 1'b0;
            addr_cap_r  <= 32'h0000_0000;
            wdata_cap_r <= 32'h0000_0000;
            be_cap_r    <= 4'b0000;
            kind_cap_r  <= 2'b00;
        end else begin
            if (rd_en_s) begin
                readdata_r <= in_range_s ? mem_r[idx_s] : 32'h0000_0000;
            end
            if (start_s) begin
                addr_cap_r  <= bus.address;
                wdata_cap_r <= bus.writedata;
                be_cap_r    <= bus.byteenable;
                kind_cap_r  <= {bus.read, bus.write};
            end
            if (req_s && (both_s || (stalled_s && changed_s))) begin
                perr_r <= 1'b1;
            end
        end
    end

    assign bus.waitrequest    = wait_s;
    assign bus.readdata       = readdata_r;
    assign bus.protocol_error = perr_r;

endmodule
